nios_key_ctrl: RTL and testbench

Debouncing, edge-capturing controller for the push-button input port of the Nios system. It replaces the plain registered key read with an Avalon-MM slave that synchronises and debounces each key. It also latches press events into a sticky edge-capture register and raises a maskable level interrupt to the CPU. It sits between the board key pins and the Nios data bus, at the same address window the key port occupies today.

---
 rtl/nios_key_ctrl_pkg.sv | 11 +
 rtl/nios_key_debounce.sv | 67 ++++++
 rtl/nios_key_ctrl.sv | 94 +++++++++
 tb/tb_nios_key_ctrl.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/nios_key_ctrl_pkg.sv
// Shared register map and debounce state encoding for the Nios key controller.
package nios_key_ctrl_pkg;

   localparam logic [1:0] KEYS_ADDR    = 2'd0;
   localparam logic [1:0] RAW_ADDR     = 2'd1;
   localparam logic [1:0] IRQMASK_ADDR = 2'd2;
   localparam logic [1:0] EDGECAP_ADDR = 2'd3;

   typedef enum logic {STABLE, CHANGING} deb_state_e;

endpackage

// File: rtl/nios_key_debounce.sv
// Single-bit debouncer: a new level is accepted only after it persists for
// STABLE_COUNT sample ticks; rise pulses in the cycle debounced goes 0 -> 1.
module nios_key_debounce
   import nios_key_ctrl_pkg::*;
#(
   parameter int unsigned STABLE_COUNT = 8
) (
   input  logic clk,
   input  logic reset,
   input  logic tick,
   input  logic sync_in,
   output logic debounced,
   output logic rise
);

   localparam int unsigned CNT_W = $clog2(STABLE_COUNT + 1);

   deb_state_e       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             deb_q, deb_d;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      deb_d   = deb_q;
      rise    = 1'b0;
      case (state_q)
         STABLE: begin
            if (sync_in != deb_q) begin
               state_d = CHANGING;
               cnt_d   = '0;
            end
         end
         CHANGING: begin
            if (sync_in == deb_q) begin
               state_d = STABLE;
               cnt_d   = '0;
            end else if (tick) begin
               // Toggle on the tick that would bring the count to STABLE_COUNT.
               if (cnt_q == CNT_W'(STABLE_COUNT - 1)) begin
                  deb_d   = ~deb_q;
                  rise    = ~deb_q;
                  state_d = STABLE;
                  cnt_d   = '0;
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= STABLE;
         cnt_q   <= '0;
         deb_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         deb_q   <= deb_d;
      end
   end

   assign debounced = deb_q;

endmodule

// File: rtl/nios_key_ctrl.sv
// Avalon-MM push-button port: synchronise, debounce, sticky press capture
// with write-one-to-clear, and a maskable registered level interrupt.
module nios_key_ctrl
   import nios_key_ctrl_pkg::*;
#(
   parameter int unsigned WIDTH        = 4,
   parameter int unsigned TICK_DIV     = 50000,
   parameter int unsigned STABLE_COUNT = 8,
   parameter bit          ACTIVE_LOW   = 1'b1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [1:0]       address,
   input  logic             chipselect,
   input  logic             write_n,
   input  logic [31:0]      writedata,
   output logic [31:0]      readdata,
   input  logic [WIDTH-1:0] in_port,
   output logic             irq
);

   localparam int unsigned TICK_W = $clog2(TICK_DIV);

   logic [WIDTH-1:0]  sync1_q, sync1_d, sync2_q, sync2_d;
   logic [TICK_W-1:0] tick_cnt_q, tick_cnt_d;
   logic [WIDTH-1:0]  irqmask_q, irqmask_d;
   logic [WIDTH-1:0]  edgecap_q, edgecap_d;
   logic [31:0]       readdata_q, readdata_d;
   logic              irq_q, irq_d;

   logic [WIDTH-1:0]  key_sync, debounced, rise, w1c;
   logic              tick, wr_en;
   logic              unused_wdata;

   assign key_sync     = ACTIVE_LOW ? ~sync2_q : sync2_q;
   assign tick         = (tick_cnt_q == TICK_W'(TICK_DIV - 1));
   assign wr_en        = chipselect & ~write_n;
   assign unused_wdata = ^writedata;

   for (genvar g = 0; g < WIDTH; g++) begin : g_key
      nios_key_debounce #(.STABLE_COUNT(STABLE_COUNT)) u_deb (
         .clk      (clk),
         .reset    (reset),
         .tick     (tick),
         .sync_in  (key_sync[g]),
         .debounced(debounced[g]),
         .rise     (rise[g])
      );
   end

   always_comb begin
      sync1_d    = in_port;
      sync2_d    = sync1_q;
      tick_cnt_d = tick ? '0 : tick_cnt_q + TICK_W'(1);
      irqmask_d  = irqmask_q;
      w1c        = '0;
      if (wr_en && address == IRQMASK_ADDR) irqmask_d = writedata[WIDTH-1:0];
      if (wr_en && address == EDGECAP_ADDR) w1c = writedata[WIDTH-1:0];
      // Rise is OR-ed after the clear so a same-cycle press survives the W1C.
      edgecap_d  = (edgecap_q & ~w1c) | rise;
      irq_d      = |(edgecap_q & irqmask_q);
      readdata_d = '0;
      case (address)
         KEYS_ADDR:    readdata_d = 32'(debounced);
         RAW_ADDR:     readdata_d = 32'(key_sync);
         IRQMASK_ADDR: readdata_d = 32'(irqmask_q);
         EDGECAP_ADDR: readdata_d = 32'(edgecap_q);
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         sync1_q    <= '0;
         sync2_q    <= '0;
         tick_cnt_q <= '0;
         irqmask_q  <= '0;
         edgecap_q  <= '0;
         readdata_q <= '0;
         irq_q      <= 1'b0;
      end else begin
         sync1_q    <= sync1_d;
         sync2_q    <= sync2_d;
         tick_cnt_q <= tick_cnt_d;
         irqmask_q  <= irqmask_d;
         edgecap_q  <= edgecap_d;
         readdata_q <= readdata_d;
         irq_q      <= irq_d;
      end
   end

   assign readdata = readdata_q;
   assign irq      = irq_q;

endmodule

// File: tb/tb_nios_key_ctrl.sv
// Directed and randomized checks of nios_key_ctrl against a cycle-level
// behavioural model using tick arithmetic instead of per-key counters.
module tb_nios_key_ctrl;

   localparam int TD = 4;
   localparam int SC = 3;

   logic        clk;
   logic        reset;
   logic [1:0]  address;
   logic        chipselect;
   logic        write_n;
   logic [31:0] writedata;
   logic [31:0] readdata;
   logic [3:0]  in_port;
   logic        irq;

   int n_cmp = 0;
   int n_bad = 0;

   // Behavioural model state
   int          k_m;
   int          dis_m [4];
   logic [3:0]  s1_m, s2_m, deb_m, mask_m, ec_m;
   logic [31:0] rd_m;
   logic        irq_m;

   nios_key_ctrl #(
      .WIDTH       (4),
      .TICK_DIV    (TD),
      .STABLE_COUNT(SC),
      .ACTIVE_LOW  (1'b1)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .address   (address),
      .chipselect(chipselect),
      .write_n   (write_n),
      .writedata (writedata),
      .readdata  (readdata),
      .in_port   (in_port),
      .irq       (irq)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // Sample ticks fall on post-reset edges k with k % TD == TD-1.
   function automatic bit ticks_done(input int start, input int kk);
      return ((kk + 1) / TD - (start + 1) / TD) >= SC;
   endfunction

   task automatic model_edge();
      logic [3:0]  key, w1c, rise;
      logic [31:0] rd_next;
      logic        irq_next;
      if (reset) begin
         k_m = 0; s1_m = '0; s2_m = '0; deb_m = '0; mask_m = '0; ec_m = '0;
         rd_m = '0; irq_m = 1'b0;
         for (int i = 0; i < 4; i++) dis_m[i] = -1;
         return;
      end
      key = ~s2_m;
      case (address)
         2'd0:    rd_next = {28'b0, deb_m};
         2'd1:    rd_next = {28'b0, key};
         2'd2:    rd_next = {28'b0, mask_m};
         default: rd_next = {28'b0, ec_m};
      endcase
      irq_next = |(ec_m & mask_m);
      w1c  = (chipselect && !write_n && address == 2'd3) ? writedata[3:0] : 4'b0;
      rise = '0;
      for (int i = 0; i < 4; i++) begin
         if (key[i] == deb_m[i]) dis_m[i] = -1;
         else if (dis_m[i] < 0) dis_m[i] = k_m;
         else if (ticks_done(dis_m[i], k_m)) begin
            deb_m[i] = ~deb_m[i];
            dis_m[i] = -1;
            rise[i]  = deb_m[i];
         end
      end
      ec_m = (ec_m & ~w1c) | rise;
      if (chipselect && !write_n && address == 2'd2) mask_m = writedata[3:0];
      rd_m  = rd_next;
      irq_m = irq_next;
      s2_m  = s1_m;
      s1_m  = in_port;
      k_m++;
   endtask

   task automatic step();
      @(posedge clk);
      model_edge();
      @(negedge clk);
      chk("rd_model", readdata, rd_m);
      chk("irq_model", 32'(irq), 32'(irq_m));
   endtask

   initial begin
      int  n;
      bit  found, saw, pred;
      int  b;

      reset = 1'b1; in_port = 4'hF; address = 2'd0;
      chipselect = 1'b0; write_n = 1'b1; writedata = '0;

      // 1: reset state
      repeat (3) step();
      chk("rst_readdata", readdata, 32'h0);
      chk("rst_irq", 32'(irq), 32'h0);
      reset = 1'b0;
      repeat (6) step();
      chk("keys_after_rst", readdata, 32'h0);

      // 2: press key 0, bounded latency
      in_port[0] = 1'b0;
      found = 0; n = 0;
      for (int c = 1; c <= 40 && !found; c++) begin
         step();
         if (readdata[0]) begin found = 1; n = c; end
      end
      chk("press_found", 32'(found), 32'h1);
      // first visible on readdata one cycle after the debounced edge
      chk("press_latency_min", 32'(n >= 2 + 1 + 9 + 1), 32'h1);
      chk("press_latency_max", 32'(n <= 2 + 1 + 12 + 1), 32'h1);
      address = 2'd3;
      step();
      chk("edgecap_k0", readdata, 32'h1);
      chk("irq_masked", 32'(irq), 32'h0);

      // 3: mask enable then W1C
      address = 2'd2; writedata = 32'h1; chipselect = 1'b1; write_n = 1'b0;
      step();
      chipselect = 1'b0; write_n = 1'b1;
      chk("irq_before_mask", 32'(irq), 32'h0);
      step();
      chk("irq_after_mask", 32'(irq), 32'h1);
      address = 2'd3; writedata = 32'h1; chipselect = 1'b1; write_n = 1'b0;
      step();
      chipselect = 1'b0; write_n = 1'b1;
      chk("irq_at_w1c", 32'(irq), 32'h1);
      step();
      chk("irq_cleared", 32'(irq), 32'h0);
      chk("edgecap_cleared", readdata, 32'h0);

      // 4: short glitch on key 1
      address = 2'd1; saw = 0;
      in_port[1] = 1'b0;
      repeat (6) begin step(); if (readdata[1]) saw = 1; end
      in_port[1] = 1'b1;
      repeat (6) begin step(); if (readdata[1]) saw = 1; end
      chk("raw_pulse_seen", 32'(saw), 32'h1);
      address = 2'd0;
      repeat (20) step();
      chk("glitch_keys1", 32'(readdata[1]), 32'h0);
      address = 2'd3;
      step();
      chk("glitch_edgecap1", 32'(readdata[1]), 32'h0);

      // 5: W1C collides with key 2 rise
      in_port[2] = 1'b0; found = 0;
      for (int c = 0; c < 40 && !found; c++) begin
         pred = (~s2_m[2] != deb_m[2]) && !deb_m[2] && dis_m[2] >= 0 && ticks_done(dis_m[2], k_m);
         if (pred) begin
            writedata = 32'h4; chipselect = 1'b1; write_n = 1'b0;
            found = 1;
         end
         step();
         chipselect = 1'b0; write_n = 1'b1;
      end
      chk("collision_hit", 32'(found), 32'h1);
      step();
      chk("set_wins", 32'(readdata[2]), 32'h1);

      // 6: reset while key 3 is changing
      in_port[3] = 1'b0;
      repeat (6) step();
      reset = 1'b1;
      repeat (2) step();
      reset = 1'b0; address = 2'd0;
      step();
      chk("rst_mid_keys", readdata, 32'h0);
      address = 2'd3;
      step();
      chk("rst_mid_edgecap", readdata, 32'h0);
      address = 2'd0; found = 0; n = 0;
      for (int c = 3; c <= 40 && !found; c++) begin
         step();
         if (readdata[3]) begin found = 1; n = c; end
      end
      chk("rst_k3_found", 32'(found), 32'h1);
      chk("rst_k3_full_interval", 32'(n >= 1 + 9 + 1 && n <= 1 + 12 + 1), 32'h1);

      // Randomized traffic against the model
      for (int c = 0; c < 1500; c++) begin
         if ($urandom_range(0, 15) == 0) begin
            b = int'($urandom_range(0, 3));
            in_port[b] = ~in_port[b];
         end
         address = 2'($urandom_range(0, 3));
         if ($urandom_range(0, 7) == 0) begin
            chipselect = 1'b1; write_n = 1'b0; writedata = $urandom;
         end else begin
            chipselect = 1'($urandom_range(0, 1));
            write_n    = chipselect ? 1'b1 : 1'($urandom_range(0, 1));
            writedata  = $urandom;
         end
         step();
      end
      chipselect = 1'b0; write_n = 1'b1;
      step();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
